// File: rtl/pll_lock_sequencer.sv
// ============================================================================
//  Module : pll_lock_sequencer
//  Brief  : Qualifies rPLL LOCK, sequences rPLL RESET and holds downstream
//           logic in reset until lock has been stable long enough.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_lock_sequencer #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int CNT_W               = 8
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic             sys_reset,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [CNT_W-1:0] retry_count,
    output logic [1:0]       state
);

    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES);
    localparam int RST_W = $clog2(PLL_RST_CYCLES);

    localparam logic [STB_W-1:0] C_STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RST_W-1:0] C_RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_PLLRST = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, lock_s_q;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic               pll_reset_q, sys_reset_q, ready_q;
    logic               w_timeout;

    assign w_timeout = (tmo_cnt_q == C_TMO_LAST);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        stb_cnt_d = stb_cnt_q;
        loss_d    = loss_q;
        retry_d   = retry_q;

        case (state_q)
            S_PLLRST: begin
                if (rst_cnt_q == C_RST_LAST) begin
                    state_d   = S_WAIT;
                    rst_cnt_d = '0;
                    tmo_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (w_timeout) begin
                    state_d   = S_PLLRST;
                    rst_cnt_d = '0;
                    if (retry_q != C_CNT_MAX) retry_d = retry_q + 1'b1;
                end else if (lock_s_q) begin
                    state_d   = S_STABLE;
                    stb_cnt_d = '0;
                end
            end
            S_STABLE: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // Completing qualification beats a coincident timeout.
                if (lock_s_q && (stb_cnt_q == C_STB_LAST)) begin
                    state_d = S_RUN;
                end else if (w_timeout) begin
                    state_d   = S_PLLRST;
                    rst_cnt_d = '0;
                    if (retry_q != C_CNT_MAX) retry_d = retry_q + 1'b1;
                end else if (!lock_s_q) begin
                    state_d = S_WAIT;
                end else begin
                    stb_cnt_d = stb_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s_q) begin
                    state_d   = S_WAIT;
                    tmo_cnt_d = '0;
                    if (loss_q != C_CNT_MAX) loss_d = loss_q + 1'b1;
                end
            end
            default: state_d = S_PLLRST;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= S_PLLRST;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            loss_q      <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            sync1_q     <= pll_lock;
            lock_s_q    <= sync1_q;
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            loss_q      <= loss_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == S_PLLRST);
            sys_reset_q <= (state_d != S_RUN);
            ready_q     <= (state_d == S_RUN);
        end
    end

    assign pll_reset       = pll_reset_q;
    assign sys_reset       = sys_reset_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_q;
    assign retry_count     = retry_q;
    assign state           = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// ============================================================================
//  Module : tb_pll_lock_sequencer
//  Brief  : Scenario bench for pll_lock_sequencer with a queue of expected
//           output snapshots {state,pll_reset,sys_reset,ready,loss,retry}.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_sequencer;

    localparam int LS = 8;
    localparam int LT = 64;
    localparam int PR = 4;
    localparam int CW = 3;

    localparam logic [1:0] ST_PLLRST = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STABLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    logic          clkin = 1'b0;
    logic          reset = 1'b1;
    logic          pll_lock = 1'b0;
    logic          pll_reset, sys_reset, ready;
    logic [CW-1:0] lock_loss_count, retry_count;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    pll_lock_sequencer #(
        .LOCK_STABLE_CYCLES (LS),
        .LOCK_TIMEOUT_CYCLES(LT),
        .PLL_RST_CYCLES     (PR),
        .CNT_W              (CW)
    ) dut (
        .clkin          (clkin),
        .reset          (reset),
        .pll_lock       (pll_lock),
        .pll_reset      (pll_reset),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .lock_loss_count(lock_loss_count),
        .retry_count    (retry_count),
        .state          (state)
    );

    always #5 clkin = ~clkin;

    function automatic logic [10:0] pk(input logic [1:0] st, input logic p, input logic s,
                                       input logic r, input logic [2:0] l, input logic [2:0] c);
        return {st, p, s, r, l, c};
    endfunction

    function automatic logic [10:0] obs();
        return {state, pll_reset, sys_reset, ready, lock_loss_count, retry_count};
    endfunction

    // Outputs are sampled 1 time unit after the active edge; inputs change there too.
    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    // Leaves the DUT just after the edge on which it entered WAIT.
    task automatic reset_dut();
        reset = 1'b1;
        pll_lock = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(PR);
    endtask

    task automatic test_reset();
        logic [10:0] e, g;
        reset = 1'b1;
        pll_lock = 1'b0;
        exp_q.push_back(pk(ST_PLLRST, 1, 1, 0, 0, 0));
        tick(1);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL reset_state got=%b exp=%b", g, e); end
        exp_q.push_back(pk(ST_PLLRST, 1, 1, 0, 0, 0));
        tick(3);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL reset_held got=%b exp=%b", g, e); end
        reset = 1'b0;
        exp_q.push_back(pk(ST_PLLRST, 1, 1, 0, 0, 0));
        tick(PR - 1);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL pllrst_last_cycle got=%b exp=%b", g, e); end
        exp_q.push_back(pk(ST_WAIT, 0, 1, 0, 0, 0));
        tick(1);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL pllrst_to_wait got=%b exp=%b", g, e); end
    endtask

    task automatic test_lock_rise();
        logic [10:0] e, g;
        reset_dut();
        tick(5);
        pll_lock = 1'b1;
        exp_q.push_back(pk(ST_STABLE, 0, 1, 0, 0, 0));
        tick(LS + 2);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL rise_edge9_stable got=%b exp=%b", g, e); end
        exp_q.push_back(pk(ST_RUN, 0, 0, 1, 0, 0));
        tick(1);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL rise_edge10_run got=%b exp=%b", g, e); end
    endtask

    // Starts in RUN with both counters at zero.
    task automatic test_lock_drop();
        logic [10:0] e, g;
        pll_lock = 1'b0;
        exp_q.push_back(pk(ST_RUN, 0, 0, 1, 0, 0));
        tick(2);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL drop_still_run got=%b exp=%b", g, e); end
        exp_q.push_back(pk(ST_WAIT, 0, 1, 0, 1, 0));
        tick(1);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL drop_to_wait got=%b exp=%b", g, e); end
        pll_lock = 1'b1;
        exp_q.push_back(pk(ST_STABLE, 0, 1, 0, 1, 0));
        tick(LS + 2);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL rerise_stable got=%b exp=%b", g, e); end
        exp_q.push_back(pk(ST_RUN, 0, 0, 1, 1, 0));
        tick(1);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL rerise_run got=%b exp=%b", g, e); end
    endtask

    task automatic test_glitch();
        logic [10:0] e, g;
        reset_dut();
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        exp_q.push_back(pk(ST_WAIT, 0, 1, 0, 0, 0));
        tick(2);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL glitch_back_to_wait got=%b exp=%b", g, e); end
        exp_q.push_back(pk(ST_STABLE, 0, 1, 0, 0, 0));
        tick(LS);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL glitch_restart_stable got=%b exp=%b", g, e); end
        exp_q.push_back(pk(ST_RUN, 0, 0, 1, 0, 0));
        tick(1);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL glitch_run got=%b exp=%b", g, e); end
    endtask

    task automatic test_timeout();
        logic [10:0] e, g;
        logic [2:0]  prev, now;
        reset_dut();
        for (int i = 1; i <= 8; i++) begin
            prev = (i - 1 > 7) ? 3'd7 : 3'(i - 1);
            now  = (i > 7) ? 3'd7 : 3'(i);
            exp_q.push_back(pk(ST_WAIT, 0, 1, 0, 0, prev));
            tick(LT - 1);
            e = exp_q.pop_front(); g = obs(); checks++;
            if (g !== e) begin errors++; $display("FAIL tmo_wait[%0d] got=%b exp=%b", i, g, e); end
            exp_q.push_back(pk(ST_PLLRST, 1, 1, 0, 0, now));
            tick(1);
            e = exp_q.pop_front(); g = obs(); checks++;
            if (g !== e) begin errors++; $display("FAIL tmo_pllrst[%0d] got=%b exp=%b", i, g, e); end
            exp_q.push_back(pk(ST_WAIT, 0, 1, 0, 0, now));
            tick(PR);
            e = exp_q.pop_front(); g = obs(); checks++;
            if (g !== e) begin errors++; $display("FAIL tmo_rewait[%0d] got=%b exp=%b", i, g, e); end
        end
    endtask

    // Lock rise timed so qualification completes on the final timeout edge.
    task automatic test_timeout_boundary();
        logic [10:0] e, g;
        reset_dut();
        tick(LT - LS - 3);
        pll_lock = 1'b1;
        exp_q.push_back(pk(ST_STABLE, 0, 1, 0, 0, 0));
        tick(LS + 2);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL bnd_stable got=%b exp=%b", g, e); end
        exp_q.push_back(pk(ST_RUN, 0, 0, 1, 0, 0));
        tick(1);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL bnd_run_wins got=%b exp=%b", g, e); end
        exp_q.push_back(pk(ST_RUN, 0, 0, 1, 0, 0));
        tick(3);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL bnd_run_hold got=%b exp=%b", g, e); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] e, g;
        reset_dut();
        pll_lock = 1'b1;
        tick(LS + 3);
        pll_lock = 1'b0;
        tick(3);
        pll_lock = 1'b1;
        exp_q.push_back(pk(ST_STABLE, 0, 1, 0, 1, 0));
        tick(4);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL mid_in_stable got=%b exp=%b", g, e); end
        reset = 1'b1;
        exp_q.push_back(pk(ST_PLLRST, 1, 1, 0, 0, 0));
        tick(1);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL rst_from_stable got=%b exp=%b", g, e); end
        reset = 1'b0;
        exp_q.push_back(pk(ST_RUN, 0, 0, 1, 0, 0));
        tick(PR + 1 + LS);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL run_after_reset got=%b exp=%b", g, e); end
        pll_lock = 1'b0;
        tick(3);
        pll_lock = 1'b1;
        exp_q.push_back(pk(ST_RUN, 0, 0, 1, 1, 0));
        tick(LS + 3);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL run_before_reset got=%b exp=%b", g, e); end
        reset = 1'b1;
        exp_q.push_back(pk(ST_PLLRST, 1, 1, 0, 0, 0));
        tick(1);
        e = exp_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL rst_from_run got=%b exp=%b", g, e); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_rise();
        test_lock_drop();
        test_glitch();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
